// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM address and fills
// the IF/ID register. Redirects that arrive under stall are buffered.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    input  logic [31:0] inst_rom_data_i,
    output logic [31:0] inst_addr_o,
    output logic        ce_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);

    logic [31:0] pc;
    logic        ce;
    logic        pend_v;
    logic [31:0] pend_tgt;
    logic        hold_pc;
    logic [31:0] next_pc;

    assign hold_pc = stall_if | stall_id;

    // Advance target: a live redirect beats a buffered one, else sequential.
    always_comb begin
        next_pc = pc + 32'd4;
        if (branch_flag_i) begin
            next_pc = branch_target_address_i;
        end else if (pend_v) begin
            next_pc = pend_tgt;
        end
    end

    // Chip enable rises on the first clock out of reset and stays high.
    always_ff @(posedge clk) begin
        if (rst) begin
            ce <= 1'b0;
        end else begin
            ce <= 1'b1;
        end
    end

    // Program counter: parked at RESET_PC until enabled, held under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (!ce) begin
            pc <= RESET_PC;
        end else if (!hold_pc) begin
            pc <= next_pc;
        end
    end

    // Pending redirect: first target seen while held wins until released.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v   <= 1'b0;
            pend_tgt <= 32'h0;
        end else if (ce) begin
            if (hold_pc) begin
                if (branch_flag_i && !pend_v) begin
                    pend_v   <= 1'b1;
                    pend_tgt <= branch_target_address_i;
                end
            end else begin
                pend_v <= 1'b0;
            end
        end
    end

    // IF/ID register: hold on ID stall, bubble on fetch stall or disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_o   <= 32'h0;
            inst_o <= 32'h0;
        end else if (stall_id) begin
            pc_o   <= pc_o;
            inst_o <= inst_o;
        end else if (stall_if || !ce) begin
            pc_o   <= 32'h0;
            inst_o <= 32'h0;
        end else begin
            pc_o   <= pc;
            inst_o <= inst_rom_data_i;
        end
    end

    assign inst_addr_o = pc;
    assign ce_o        = ce;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; ROM word at address a is a + 32'h1000_0000.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_if;
    logic        stall_id;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic [31:0] inst_rom_data_i;
    logic [31:0] inst_addr_o;
    logic        ce_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;

    int n_checks = 0;
    int n_fail   = 0;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall_if                (stall_if),
        .stall_id                (stall_id),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .inst_rom_data_i         (inst_rom_data_i),
        .inst_addr_o             (inst_addr_o),
        .ce_o                    (ce_o),
        .pc_o                    (pc_o),
        .inst_o                  (inst_o)
    );

    always #5 clk = ~clk;

    assign inst_rom_data_i = inst_addr_o + 32'h1000_0000;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input logic [31:0] a,
                        input logic [31:0] p, input logic [31:0] i);
        chk({tag, ".addr"}, inst_addr_o, a);
        chk({tag, ".pc_o"}, pc_o, p);
        chk({tag, ".inst"}, inst_o, i);
    endtask

    initial begin
        rst = 1'b1;
        stall_if = 1'b0;
        stall_id = 1'b0;
        branch_flag_i = 1'b0;
        branch_target_address_i = 32'h0;
        step();
        step();
        chk("rst.ce", {31'h0, ce_o}, 32'h0);
        chk3("rst", 32'h0, 32'h0, 32'h0);

        // Test 1: sequential fetch
        rst = 1'b0;
        step();
        chk("en.ce", {31'h0, ce_o}, 32'h1);
        chk3("bubble", 32'h0, 32'h0, 32'h0);
        step();
        chk3("seq0", 32'h4, 32'h0, 32'h1000_0000);
        step();
        chk3("seq1", 32'h8, 32'h4, 32'h1000_0004);
        step();
        step();
        chk3("seq3", 32'h10, 32'hC, 32'h1000_000C);
        step();
        chk3("seq4", 32'h14, 32'h10, 32'h1000_0010);

        // Test 2: branch at 0x10, delay slot 0x14 passes through
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h100;
        #1;
        chk("br.addr_pre", inst_addr_o, 32'h14);
        step();
        branch_flag_i = 1'b0;
        chk3("br.slot", 32'h100, 32'h14, 32'h1000_0014);
        step();
        chk3("br.tgt", 32'h104, 32'h100, 32'h1000_0100);

        // Test 3: full stall for 3 cycles
        stall_if = 1'b1;
        stall_id = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk3("stall", 32'h104, 32'h100, 32'h1000_0100);
        end
        stall_if = 1'b0;
        stall_id = 1'b0;
        step();
        chk3("stall.rel", 32'h108, 32'h104, 32'h1000_0104);

        // Test 4: redirect under fetch-only stall, flag dropped after
        stall_if = 1'b1;
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h200;
        step();
        chk3("pend.bub", 32'h108, 32'h0, 32'h0);
        stall_if = 1'b0;
        branch_flag_i = 1'b0;
        branch_target_address_i = 32'h0;
        step();
        chk3("pend.apply", 32'h200, 32'h108, 32'h1000_0108);
        step();
        chk3("pend.next", 32'h204, 32'h200, 32'h1000_0200);

        // Test 5: wrap at top of address space
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'hFFFF_FFFC;
        step();
        branch_flag_i = 1'b0;
        chk("wrap.top", inst_addr_o, 32'hFFFF_FFFC);
        step();
        chk3("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0FFF_FFFC);
        step();
        chk3("wrap.next", 32'h4, 32'h0, 32'h1000_0000);

        // Second redirect while pending is ignored
        stall_if = 1'b1;
        stall_id = 1'b1;
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h300;
        step();
        branch_target_address_i = 32'h400;
        step();
        chk3("pend2.hold", 32'h4, 32'h0, 32'h1000_0000);
        stall_if = 1'b0;
        stall_id = 1'b0;
        branch_flag_i = 1'b0;
        step();
        chk3("pend2.first", 32'h300, 32'h4, 32'h1000_0004);

        // Live flag on release beats the buffered target
        stall_if = 1'b1;
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h500;
        step();
        chk("live.hold", inst_addr_o, 32'h300);
        stall_if = 1'b0;
        branch_target_address_i = 32'h600;
        step();
        branch_flag_i = 1'b0;
        chk3("live.win", 32'h600, 32'h300, 32'h1000_0300);

        // Test 6: reset while a redirect is pending
        stall_if = 1'b1;
        stall_id = 1'b1;
        branch_flag_i = 1'b1;
        branch_target_address_i = 32'h700;
        step();
        rst = 1'b1;
        branch_flag_i = 1'b0;
        step();
        chk("rst2.ce", {31'h0, ce_o}, 32'h0);
        chk3("rst2", 32'h0, 32'h0, 32'h0);
        rst = 1'b0;
        stall_if = 1'b0;
        stall_id = 1'b0;
        step();
        chk3("rst2.en", 32'h0, 32'h0, 32'h0);
        step();
        chk3("rst2.seq", 32'h4, 32'h0, 32'h1000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
